// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin write arbiter for a shared register bank with registered read port (optional RD_BYPASS_EN write-first read)
module reg_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   wr_addr,
  input  logic [NREQ*W-1:0]    wr_data,
  output logic [NREQ-1:0]      gnt,
  input  logic [AW-1:0]        rd_addr,
  output logic [W-1:0]         rd_data,
  output logic [15:0]          wr_cnt
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [W-1:0]    bank_q [DEPTH];
  logic [W-1:0]    bank_d [DEPTH];
  logic [NREQ-1:0] gnt_q, gnt_d, elig, rot, oh;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]    rd_data_q, rd_data_d, wd;
  logic [15:0]     wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]   wa;
  logic            we, wr_ok, rd_ok;
  int              off;
  assign elig  = req & ~gnt_q;
  assign rot   = NREQ'({elig, elig} >> ptr_q);
  assign wr_ok = 32'(wa) < DEPTH;
  assign rd_ok = 32'(rd_addr) < DEPTH;
  // pick the first eligible requester at or after ptr, rotate its one-hot back into place
  always_comb begin
    off = 0;
    oh  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = i;
        oh    = '0;
        oh[i] = 1'b1;
      end
    end
    gnt_d = NREQ'(({oh, oh} << ptr_q) >> NREQ);
    ptr_d = |rot ? PW'((int'(ptr_q) + off + 1) % NREQ) : ptr_q;
  end
  // the granted requester's address/data are taken at the edge closing its grant cycle
  always_comb begin
    we = 1'b0;
    wa = '0;
    wd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        we = 1'b1;
        wa = wr_addr[i*AW +: AW];
        wd = wr_data[i*W +: W];
      end
    end
  end
  // bank update, write count and read mux; out-of-range writes still count but leave the bank alone
  always_comb begin
    bank_d   = bank_q;
    if (we && wr_ok) bank_d[wa] = wd;
    wr_cnt_d = wr_cnt_q + 16'(we);
`ifdef RD_BYPASS_EN
    rd_data_d = (we && wr_ok && wa == rd_addr) ? wd : rd_ok ? bank_q[rd_addr] : '0;
`else
    rd_data_d = rd_ok ? bank_q[rd_addr] : '0;
`endif
  end
  // all state cleared while rst is low; a grant pending at that edge is dropped without writing
  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_q    <= '{default: '0};
      gnt_q     <= '0;
      ptr_q     <= '0;
      rd_data_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      bank_q    <= bank_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      rd_data_q <= rd_data_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end
  assign gnt     = gnt_q;
  assign rd_data = rd_data_q;
  assign wr_cnt  = wr_cnt_q;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: scoreboard bench for reg_bank_arbiter (NREQ=4, W=8, DEPTH=12)
module tb_reg_bank_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  gnt;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [15:0] wr_cnt;
  logic [27:0] q_exp [$];
  logic [27:0] e;
  int errors = 0;
  int checks = 0;
`ifdef RD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reg_bank_arbiter #(.NREQ(4), .W(8), .DEPTH(12)) dut (
    .clk(clk), .rst(rst), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
    .gnt(gnt), .rd_addr(rd_addr), .rd_data(rd_data), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic reset_dut;
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req = 4'b1111;
    wr_addr = 16'h3210;
    wr_data = 32'h44332211;
    rd_addr = 4'd0;
    for (int k = 0; k < 2; k++) begin
      q_exp.push_back({4'b0000, 16'h0000, 8'h00});
      @(negedge clk);
      e = q_exp.pop_front();
      checks++;
      if ({gnt, wr_cnt, rd_data} !== e) begin
        errors++;
        $display("FAIL reset cyc %0d: got gnt=%b cnt=%h rd=%h want gnt=%b cnt=%h rd=%h", k, gnt, wr_cnt, rd_data, e[27:24], e[23:8], e[7:0]);
      end
    end
    rst = 1'b1;
    req = '0;
    for (int a = 0; a < 12; a++) begin
      rd_addr = 4'(a);
      q_exp.push_back({4'b0000, 16'h0000, 8'h00});
      @(negedge clk);
      e = q_exp.pop_front();
      checks++;
      if ({gnt, wr_cnt, rd_data} !== e) begin
        errors++;
        $display("FAIL reset_bank addr %0d: got gnt=%b cnt=%h rd=%h want gnt=%b cnt=%h rd=%h", a, gnt, wr_cnt, rd_data, e[27:24], e[23:8], e[7:0]);
      end
    end
  endtask

  task automatic test_single;
    reset_dut();
    wr_addr = 16'h0030;
    wr_data = 32'h0000A500;
    rd_addr = 4'd3;
    req = 4'b0010;
    for (int c = 0; c < 6; c++)
      q_exp.push_back({(c % 2 == 0) ? 4'b0010 : 4'b0000, 16'((c + 1) / 2),
                       c == 0 ? 8'h00 : (c == 1 && !BYP) ? 8'h00 : 8'hA5});
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      e = q_exp.pop_front();
      checks++;
      if ({gnt, wr_cnt, rd_data} !== e) begin
        errors++;
        $display("FAIL single cyc %0d: got gnt=%b cnt=%h rd=%h want gnt=%b cnt=%h rd=%h", c, gnt, wr_cnt, rd_data, e[27:24], e[23:8], e[7:0]);
      end
    end
    req = '0;
  endtask

  task automatic test_contention;
    reset_dut();
    wr_addr = 16'h3210;
    wr_data = 32'h13121110;
    rd_addr = 4'd0;
    req = 4'b1111;
    for (int k = 1; k <= 8; k++)
      q_exp.push_back({4'b0001 << ((k - 1) % 4), 16'(k - 1),
                       k == 1 ? 8'h00 : (k == 2 && !BYP) ? 8'h00 : 8'h10});
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      e = q_exp.pop_front();
      checks++;
      if ({gnt, wr_cnt, rd_data} !== e) begin
        errors++;
        $display("FAIL contention cyc %0d: got gnt=%b cnt=%h rd=%h want gnt=%b cnt=%h rd=%h", k, gnt, wr_cnt, rd_data, e[27:24], e[23:8], e[7:0]);
      end
    end
    req = '0;
    for (int a = 0; a < 4; a++) begin
      rd_addr = 4'(a);
      q_exp.push_back({4'b0000, 16'd8, 8'(8'h10 + a)});
      @(negedge clk);
      e = q_exp.pop_front();
      checks++;
      if ({gnt, wr_cnt, rd_data} !== e) begin
        errors++;
        $display("FAIL contention_bank addr %0d: got gnt=%b cnt=%h rd=%h want gnt=%b cnt=%h rd=%h", a, gnt, wr_cnt, rd_data, e[27:24], e[23:8], e[7:0]);
      end
    end
  endtask

  task automatic test_bypass;
    reset_dut();
    wr_addr = 16'h0005;
    wr_data = 32'h0000003C;
    rd_addr = 4'd5;
    req = 4'b0001;
    q_exp.push_back({4'b0001, 16'd0, 8'h00});
    q_exp.push_back({4'b0000, 16'd1, BYP ? 8'h3C : 8'h00});
    q_exp.push_back({4'b0001, 16'd1, 8'h3C});
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      e = q_exp.pop_front();
      checks++;
      if ({gnt, wr_cnt, rd_data} !== e) begin
        errors++;
        $display("FAIL bypass cyc %0d: got gnt=%b cnt=%h rd=%h want gnt=%b cnt=%h rd=%h", k, gnt, wr_cnt, rd_data, e[27:24], e[23:8], e[7:0]);
      end
    end
    req = '0;
  endtask

  task automatic test_reset_mid;
    reset_dut();
    wr_addr = 16'hA710;
    wr_data = 32'h55FF2200;
    rd_addr = 4'd7;
    req = 4'b0100;
    for (int k = 1; k <= 5; k++) begin
      case (k)
        1: q_exp.push_back({4'b0100, 16'd0, 8'h00});
        2: q_exp.push_back({4'b0000, 16'd0, 8'h00});
        3: q_exp.push_back({4'b0100, 16'd0, 8'h00});
        4: q_exp.push_back({4'b1000, 16'd1, 8'h00});
        default: q_exp.push_back({4'b0000, 16'd2, 8'h00});
      endcase
      @(negedge clk);
      e = q_exp.pop_front();
      checks++;
      if ({gnt, wr_cnt, rd_data} !== e) begin
        errors++;
        $display("FAIL reset_mid cyc %0d: got gnt=%b cnt=%h rd=%h want gnt=%b cnt=%h rd=%h", k, gnt, wr_cnt, rd_data, e[27:24], e[23:8], e[7:0]);
      end
      if (k == 1) rst = 1'b0;
      if (k == 2) begin
        rst = 1'b1;
        req = 4'b1100;
        wr_addr = 16'hA910;
        wr_data = 32'h55442200;
      end
      if (k == 4) req = '0;
    end
  endtask

  task automatic test_out_of_range;
    reset_dut();
    wr_addr = 16'h000D;
    wr_data = 32'h00000077;
    rd_addr = 4'd13;
    req = 4'b0001;
    q_exp.push_back({4'b0001, 16'd0, 8'h00});
    q_exp.push_back({4'b0000, 16'd1, 8'h00});
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      e = q_exp.pop_front();
      checks++;
      if ({gnt, wr_cnt, rd_data} !== e) begin
        errors++;
        $display("FAIL oob cyc %0d: got gnt=%b cnt=%h rd=%h want gnt=%b cnt=%h rd=%h", k, gnt, wr_cnt, rd_data, e[27:24], e[23:8], e[7:0]);
      end
      if (k == 1) req = '0;
    end
    for (int a = 0; a < 14; a++) begin
      rd_addr = 4'(a);
      q_exp.push_back({4'b0000, 16'd1, 8'h00});
      @(negedge clk);
      e = q_exp.pop_front();
      checks++;
      if ({gnt, wr_cnt, rd_data} !== e) begin
        errors++;
        $display("FAIL oob_bank addr %0d: got gnt=%b cnt=%h rd=%h want gnt=%b cnt=%h rd=%h", a, gnt, wr_cnt, rd_data, e[27:24], e[23:8], e[7:0]);
      end
    end
  endtask

  task automatic test_wrap;
    reset_dut();
    wr_addr = 16'h3210;
    wr_data = 32'h13121110;
    rd_addr = 4'd0;
    req = 4'b1111;
    q_exp.push_back({4'b1000, 16'hFFFF, 8'h10});
    q_exp.push_back({4'b0001, 16'h0000, 8'h10});
    repeat (65535) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      e = q_exp.pop_front();
      checks++;
      if ({gnt, wr_cnt, rd_data} !== e) begin
        errors++;
        $display("FAIL wrap step %0d: got gnt=%b cnt=%h rd=%h want gnt=%b cnt=%h rd=%h", k, gnt, wr_cnt, rd_data, e[27:24], e[23:8], e[7:0]);
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_bypass();
    test_reset_mid();
    test_out_of_range();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Round-robin write arbiter and sequencer for a shared bank of DEPTH clocked registers of width W, each a synchronous-reset D flip-flop word. NREQ requesters post write requests; the block grants one per cycle, performs the write, and exposes a registered read port plus a write counter. It sits between client logic and the bank, so no client drives bank registers directly. All bank writes are nonblocking and happen on the edge that ends the grant cycle.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 8, data width per bank word
- DEPTH, 16, number of bank words (need not be a power of two)
- AW, $clog2(DEPTH), address width (derived, do not override)
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  reset, synchronous, active-low: sampled on posedge clk, state cleared when rst==0
- req  input  NREQ  per-requester write request, level; hold until gnt seen
- wr_addr  input  NREQ*AW  flattened addresses, requester i at [i*AW +: AW]
- wr_data  input  NREQ*W  flattened data, requester i at [i*W +: W]
- gnt  output  NREQ  registered one-hot grant, one-cycle pulse per accepted write
- rd_addr  input  AW  read address
- rd_data  output  W  registered read data
- wr_cnt  output  16  count of completed writes, wraps 16'hFFFF -> 0

## Operation
- State: bank[DEPTH], round-robin pointer ptr (0..NREQ-1), gnt register, rd_data register, wr_cnt.
- Arbitration each edge (rst==1): eligible = req & ~gnt (currently granted requester excluded, so one requester never gets back-to-back grants). Winner = first eligible index scanning ptr, ptr+1, ... mod NREQ. gnt <= onehot(winner), or 0 if none eligible.
- Pointer: on an edge that loads a nonzero grant to winner k, ptr <= (k+1) mod NREQ; otherwise unchanged.
- Write: on each edge where gnt[i]==1 (grant cycle ends), bank[wr_addr_i] <= wr_data_i and wr_cnt <= wr_cnt+1. Address/data sampled at that edge, not at request time; requester holds them stable while req is high.
- Out-of-range address (wr_addr_i >= DEPTH): grant still issued, wr_cnt still increments, bank unchanged.
- Requester protocol: sees gnt[i] high during cycle; may drop req or present the next write at the following edge. If req[i] stays high it is re-arbitrated no earlier than one cycle after the grant pulse.
- Read: each edge rd_data <= bank[rd_addr]; rd_addr >= DEPTH yields 0.
- Reset (rst==0 at edge): bank all 0, gnt 0, ptr 0, rd_data 0, wr_cnt 0; no write at that edge even if gnt was high. Priority: reset over everything.
- Reset mid-operation: a pending grant is discarded (write lost); requests still high after release re-arbitrate from ptr 0.

## Timing
- Request-to-grant: req rising before edge E with no contention -> gnt high in cycle after E (1 cycle).
- Grant-to-write: bank word updated at the edge ending the gnt cycle; visible on rd_data one further edge later (without bypass).
- Read latency: 1 cycle rd_addr -> rd_data.
- Throughput: one write per cycle when >=2 requesters are active; a lone requester gets at most one grant every 2 cycles.
- Fairness: with all NREQ requesting continuously, each is granted exactly once per NREQ grants.
- Outputs after reset: gnt=0, rd_data=0, wr_cnt=0.

## Configuration
- RD_BYPASS_EN defined: if a write to address A occurs at the same edge that samples rd_addr==A, rd_data takes the new wr_data (write-first).
- RD_BYPASS_EN undefined: rd_data takes the old bank[A] value at that edge (read-first); new value appears one cycle later.

## Test plan
- Reset: drive rst=0 for 2 cycles with req=4'b1111 -> gnt=0, wr_cnt=0, rd_data=0 every cycle; bank reads 0 at all addresses.
- Single requester: req=4'b0010, addr=3, data=8'hA5 held -> gnt=0010 every other cycle; after first write rd_addr=3 gives 8'hA5; wr_cnt increments every 2 cycles.
- Full contention: req=4'b1111 held, distinct addrs 0..3 -> gnt sequence 0001,0010,0100,1000,0001...; wr_cnt +1 every cycle.
- Bypass: requester 0 writes addr 5 data 8'h3C while rd_addr=5, prior value 8'h00 -> rd_data=8'h3C at write edge with RD_BYPASS_EN, 8'h00 then 8'h3C one cycle later without.
- Reset mid-grant: assert rst=0 during gnt=0100 cycle for addr 7 data 8'hFF -> bank[7] stays 0, ptr=0, first grant after release goes to lowest requesting index.
- Edge cases: DEPTH=12, write to addr 13 -> granted, wr_cnt+1, bank unchanged, rd_addr=13 gives 0; wr_cnt preloaded via 65535 writes -> wraps to 0.
